oa_tree_seq_ctrl: RTL and testbench
===================================

Name: oa_tree_seq_ctrl

Overview:
- Sequencer for the digit-serial online-adder (OA) tree in the DSLOT-NN neuron datapath.
- Frames one dot-product evaluation: enables upstream digit feed for N_DIGITS cycles and counts the tree's online delay.
- Captures the MSD-first output digit stream.
- Terminates early when the leading nonzero output digit is negative (ReLU output is known to be zero), then flushes the tree pipeline with zero digits before reporting done.

Parameters:
- N_DIGITS, 8, digits per operand and per output frame (>=1).
- TREE_DELAY, 9, cycles from first input digit to first valid tree output digit (>=1).
- CNT_W, 5, counter width; must hold TREE_DELAY+N_DIGITS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- busy  out  1  high in FEED, DRAIN, FLUSH.
- in_en  out  1  upstream presents operand digit digit_idx to the tree; when low, upstream drives zero digits.
- digit_idx  out  CNT_W  index of input digit being fed (0..N_DIGITS-1); 0 outside FEED.
- z_p  in  1  tree output digit, positive rail.
- z_n  in  1  tree output digit, negative rail.
- out_valid  out  1  out_p/out_n carry a result digit this cycle.
- out_p  out  1  registered result digit, positive rail.
- out_n  out  1  registered result digit, negative rail.
- neg_term  out  1  sticky; frame ended by negative-sign detection.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Digit encoding (p,n): (1,0)=+1, (0,1)=-1, (0,0)/(1,1)=0.
- Reset (async, any time, including mid-frame): state IDLE, cycle counter 0, sign-seen flag 0. All outputs 0, including neg_term and done.
- States: IDLE, FEED, DRAIN, FLUSH, DONE. Internal counter cyc is cleared on entry to FEED and to FLUSH.
- IDLE: start=1 -> FEED next cycle, and neg_term and sign-seen are cleared.
- FEED: in_en=1, digit_idx=cyc, cyc increments each cycle. At cyc=N_DIGITS-1 -> DRAIN, or -> DONE if capture already finished.
- DRAIN: in_en=0, cyc keeps incrementing. At cyc=TREE_DELAY+N_DIGITS-1 -> DONE.
- Capture window: cyc in [TREE_DELAY, TREE_DELAY+N_DIGITS-1], spanning FEED or DRAIN.
  - z_p/z_n are sampled each cycle in the window.
  - Unless termination fires, out_p/out_n/out_valid are registered one cycle later.
  - Digit k of the result is therefore on the outputs at (first FEED cycle)+TREE_DELAY+k+1.
- Sign tracking: the first nonzero sampled digit sets sign-seen.
  - If that digit is +1: continue normally.
  - If that digit is -1: the digit is not emitted (out_valid stays 0 next cycle); neg_term=1 from next cycle; state -> FLUSH.
  - Digits after sign-seen=1 are never inspected for termination.
  - An all-zero result completes normally with neg_term=0.
- FLUSH: in_en=0, out_valid=0, runs exactly TREE_DELAY cycles (cyc 0..TREE_DELAY-1), then -> DONE. Termination during FEED also drops in_en immediately.
- DONE: exactly one cycle; done=1, busy=0. The last normal result digit is on the outputs in this cycle. Returns to IDLE.
- Re-trigger: start in DONE or any busy state is ignored. start in IDLE the cycle after DONE is accepted.
- Output levels: out_p/out_n are 0 whenever out_valid=0. neg_term holds until the next accepted start or reset.

Test Plan:
- Normal frame, N=8, D=9, start sampled at cycle 0, z stream +1,0,-1,0,0,0,0,+1:
  - in_en high on cycles 1-8 with digit_idx 0..7.
  - out_valid high on cycles 11-18, digits in order.
  - done on cycle 18, neg_term=0, busy low from cycle 18.
- Early termination, z digits 0,0,-1 at sample cycles 10,11,12:
  - out_valid on cycles 11-12 (zeros).
  - Cycle 13: no valid output, neg_term=1.
  - FLUSH on cycles 13-21, done on cycle 22.
- Leading +1 then -1 digits: full 8-digit frame emitted, neg_term=0, done on cycle 18.
- All-zero z for the whole frame: 8 zero digits emitted, neg_term=0, done on cycle 18.
- start pulsed on cycles 5 and 18 during a frame: ignored. start at cycle 19 is accepted and in_en rises at cycle 20.
- rst asserted asynchronously mid-DRAIN and mid-FLUSH: all outputs 0 immediately; the next start runs a clean frame with normal timing.

Source files
------------

// File: rtl/oa_tree_seq_ctrl.sv
// Sequencer for the digit-serial online-adder tree: frames one dot product,
// feeds N_DIGITS input digits, captures the MSD-first result stream and
// terminates early (then flushes) when the leading nonzero output digit is -1.
// Latency: result digit k appears on out_p/out_n at first FEED cycle + TREE_DELAY + k + 1.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            begin a frame (IDLE only)
//   busy             high in FEED, DRAIN, FLUSH
//   in_en, digit_idx upstream digit-feed enable and index (index is 0 outside FEED)
//   z_p, z_n         tree output digit, signed-digit rails
//   out_valid/p/n    registered result digit
//   neg_term         sticky flag: frame ended on negative-sign detection
//   done             one-cycle completion pulse
module oa_tree_seq_ctrl #(
    parameter int N_DIGITS   = 8,
    parameter int TREE_DELAY = 9,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             in_en,
    output logic [CNT_W-1:0] digit_idx,
    input  logic             z_p,
    input  logic             z_n,
    output logic             out_valid,
    output logic             out_p,
    output logic             out_n,
    output logic             neg_term,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] WIN_FIRST  = CNT_W'(TREE_DELAY);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(TREE_DELAY + N_DIGITS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(TREE_DELAY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             sign_seen_q, sign_seen_d;
    logic             neg_term_q, neg_term_d;
    logic             out_valid_q, out_valid_d;
    logic             out_p_q, out_p_d;
    logic             out_n_q, out_n_d;

    logic in_window;
    logic z_pos;
    logic z_neg;
    logic neg_hit;

    always_comb begin
        // The capture window is measured from the first FEED cycle, so it only
        // exists while the frame counter is running (FEED/DRAIN), never in FLUSH.
        in_window = ((state_q == S_FEED) || (state_q == S_DRAIN)) &&
                    (cyc_q >= WIN_FIRST) && (cyc_q <= WIN_LAST);
        z_pos     = z_p & ~z_n;
        z_neg     = z_n & ~z_p;
        neg_hit   = in_window & ~sign_seen_q & z_neg;
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        sign_seen_d = sign_seen_q;
        neg_term_d  = neg_term_q;
        out_valid_d = 1'b0;
        out_p_d     = 1'b0;
        out_n_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FEED;
                    cyc_d       = '0;
                    neg_term_d  = 1'b0;
                    sign_seen_d = 1'b0;
                end
            end
            S_FEED: begin
                cyc_d = cyc_q + CNT_W'(1);
                // Capture can only already be complete here if TREE_DELAY were 0;
                // kept so the FEED exit is correct for any legal parameter set.
                if (cyc_q == WIN_LAST) begin
                    state_d = S_DONE;
                end else if (cyc_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == WIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sign tracking overrides the normal frame progression: a leading -1
        // means the ReLU output is zero, so the digit is swallowed and the tree
        // is flushed. Once any nonzero digit has been seen the sign is settled.
        if (in_window) begin
            if (neg_hit) begin
                state_d     = S_FLUSH;
                cyc_d       = '0;
                neg_term_d  = 1'b1;
                sign_seen_d = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_p_d     = z_p;
                out_n_d     = z_n;
                if (z_pos) begin
                    sign_seen_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            sign_seen_q <= 1'b0;
            neg_term_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= 1'b0;
            out_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            sign_seen_q <= sign_seen_d;
            neg_term_q  <= neg_term_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_n_q     <= out_n_d;
        end
    end

    always_comb begin
        busy      = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
        in_en     = (state_q == S_FEED);
        digit_idx = (state_q == S_FEED) ? cyc_q : '0;
        done      = (state_q == S_DONE);
        out_valid = out_valid_q;
        out_p     = out_p_q;
        out_n     = out_n_q;
        neg_term  = neg_term_q;
    end

endmodule

// File: tb/tb_oa_tree_seq_ctrl.sv
// Directed bench for oa_tree_seq_ctrl (N_DIGITS=8, TREE_DELAY=9, CNT_W=5).
// Frame cycles are counted from the IDLE cycle in which start is sampled (c=0).
// Outputs are sampled 1 time unit after each rising edge.
module tb_oa_tree_seq_ctrl;

    localparam logic [1:0] P = 2'b10;  // +1
    localparam logic [1:0] M = 2'b01;  // -1
    localparam logic [1:0] Z = 2'b00;  //  0

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       in_en;
    logic [4:0] digit_idx;
    logic       z_p;
    logic       z_n;
    logic       out_valid;
    logic       out_p;
    logic       out_n;
    logic       neg_term;
    logic       done;

    int checks;
    int failures;
    logic last_neg;

    oa_tree_seq_ctrl #(
        .N_DIGITS  (8),
        .TREE_DELAY(9),
        .CNT_W     (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .in_en    (in_en),
        .digit_idx(digit_idx),
        .z_p      (z_p),
        .z_n      (z_n),
        .out_valid(out_valid),
        .out_p    (out_p),
        .out_n    (out_n),
        .neg_term (neg_term),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_in_en"},     32'(in_en),     32'd0);
        chk({tag, "_digit_idx"}, 32'(digit_idx), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_pn"},    32'({out_p, out_n}), 32'd0);
        chk({tag, "_neg_term"},  32'(neg_term),  32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
    endtask

    // zd: digit k of the tree stream at zd[2k+1:2k] as {p,n}, presented in sample cycle 10+k.
    // term_k: index of the leading -1 digit, or -1 for a normal frame.
    // abort_c: stop after checking that cycle (reset tests), -1 to run to DONE.
    task automatic run_frame(input string name, input logic [15:0] zd, input int term_k,
                             input bit retrig, input int abort_c);
        bit   term;
        int   tc;
        int   done_c;
        int   last_c;
        bit   e_busy, e_in_en, e_valid, e_neg, e_done;
        int   e_idx;
        logic [1:0] e_dig;
        logic [1:0] cur;
        term   = (term_k >= 0);
        tc     = 10 + term_k;
        done_c = term ? tc + 10 : 18;
        last_c = (abort_c >= 0) ? abort_c : done_c;
        for (int c = 0; c <= last_c; c++) begin
            start = (c == 0) || (retrig && (c == 5 || c == done_c));
            if (c >= 10 && c <= 17) cur = zd[2*(c-10) +: 2];
            else                    cur = Z;
            {z_p, z_n} = cur;

            e_busy  = (c >= 1) && (c < done_c);
            e_in_en = (c >= 1) && (c <= 8) && !(term && c > tc);
            e_idx   = e_in_en ? c - 1 : 0;
            e_valid = (c >= 11) && (c <= 18) && !(term && c > tc);
            e_dig   = e_valid ? zd[2*(c-11) +: 2] : Z;
            e_neg   = (c == 0) ? last_neg : (term && c > tc);
            e_done  = (c == done_c);

            chk($sformatf("%s_c%0d_busy", name, c),      32'(busy),             32'(e_busy));
            chk($sformatf("%s_c%0d_in_en", name, c),     32'(in_en),            32'(e_in_en));
            chk($sformatf("%s_c%0d_digit_idx", name, c), 32'(digit_idx),        32'(e_idx));
            chk($sformatf("%s_c%0d_out_valid", name, c), 32'(out_valid),        32'(e_valid));
            chk($sformatf("%s_c%0d_out_pn", name, c),    32'({out_p, out_n}),   32'(e_dig));
            chk($sformatf("%s_c%0d_neg_term", name, c),  32'(neg_term),         32'(e_neg));
            chk($sformatf("%s_c%0d_done", name, c),      32'(done),             32'(e_done));

            if (c < last_c) step();
        end
        start    = 1'b0;
        {z_p, z_n} = Z;
        last_neg = (abort_c >= 0) ? 1'b0 : term;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero(tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        last_neg = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_neg = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        z_p      = 1'b0;
        z_n      = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        chk_all_zero("idle_after_reset");

        // Normal frame: +1,0,-1,0,0,0,0,+1 (digit 0 in the low bits).
        run_frame("normal", {P, Z, Z, Z, Z, M, Z, P}, -1, 1'b0, -1);
        step();

        // Early termination: 0,0,-1 then nonzero garbage that must not surface.
        run_frame("term", {P, M, P, P, P, M, Z, Z}, 2, 1'b0, -1);
        step();
        chk("term_neg_term_held_idle", 32'(neg_term), 32'd1);

        // Leading +1 then -1: sign settled positive, full frame emitted.
        run_frame("pos_then_neg", {M, P, M, M, Z, P, M, P}, -1, 1'b0, -1);
        step();

        // All-zero result completes normally.
        run_frame("all_zero", 16'h0000, -1, 1'b0, -1);
        step();

        // start at c=5 and in DONE are ignored; the IDLE cycle after DONE accepts.
        run_frame("retrig", {Z, P, Z, M, P, Z, Z, P}, -1, 1'b1, -1);
        step();
        run_frame("after_retrig", {P, P, P, P, P, P, P, P}, -1, 1'b0, -1);
        step();

        // Async reset mid-DRAIN, then a clean frame.
        run_frame("drain_abort", {P, Z, Z, Z, Z, Z, Z, P}, -1, 1'b0, 13);
        async_reset("rst_mid_drain");
        run_frame("clean1", {Z, Z, P, M, Z, Z, Z, P}, -1, 1'b0, -1);
        step();

        // Async reset mid-FLUSH (neg_term already set), then a clean frame.
        run_frame("flush_abort", {Z, Z, Z, Z, Z, Z, M, Z}, 1, 1'b0, 16);
        async_reset("rst_mid_flush");
        run_frame("clean2", {M, Z, Z, Z, Z, Z, P, Z}, -1, 1'b0, -1);
        step();
        chk_all_zero("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
